uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver for the SoC UART, directly downstream of the transmitter.
- Frame: start bit 0, 8 data bits LSB first, optional odd-parity bit when ChkEn=1 (parity = ~^data), one stop bit 1.
- Oversamples RxD on a baud-rate enable tick and recovers the byte.
- Flags parity, framing and overrun errors.
- Presents the byte to the bus side with a valid/read handshake and a one-cycle receive interrupt.

Parameters:
- OVS, 16, ticks per bit period (even, ≥8).
- CW, 4, tick-counter width (≥ clog2(OVS)).

Ports:
- clk    in   1  system clock
- rst    in   1  reset, synchronous, active-high
- en     in   1  receiver enable
- ChkEn  in   1  parity bit present/checked
- tick   in   1  oversample enable, OVS pulses per bit period, one clk wide
- RxD    in   1  serial line, asynchronous, idle high
- rd     in   1  one-clk pulse: bus has read dat
- dat    out  8  last received byte
- dat_vld out 1  dat holds an unread byte
- RINT   out  1  one-clk pulse on frame completion
- PERR   out  1  parity error of the frame in dat
- FERR   out  1  stop-bit error of the frame in dat
- OERR   out  1  overrun: a frame completed while dat_vld=1
- busy   out  1  frame reception in progress

Behaviour:
- Reset values: dat=0, dat_vld=0, RINT=0, PERR=0, FERR=0, OERR=0, busy=0; synchronizer flops reset to 1; state IDLE.
- Reset mid-frame aborts with no RINT.
- RxD passes through a 2-FF synchronizer. A falling edge is detected as sync_q=1 and sync_d=0, so a line held low never re-triggers.
- Tick counter tc advances only on tick and clears on every state change.
- Each sample is the majority of the synchronized RxD at tc = OVS/2-1, OVS/2 and OVS/2+1.
- A bit period ends at tc = OVS-1 on tick.
- States:
  - IDLE: busy=0. Falling edge and en=1 -> START.
  - START: busy=1. Majority sample = 1 -> IDLE (false start, no flags). At end of period -> DATA, bc=0.
  - DATA: samples shift into a shift register LSB first. After bit bc=7 -> PARITY if ChkEn else STOP.
  - PARITY: pbit captured -> STOP.
  - STOP: on the tick at tc=OVS/2+1, complete the frame and go -> IDLE. The remaining half stop period is not waited.
- Frame completion, registered in the clk after that tick:
  - dat <= shift register.
  - PERR <= ChkEn & (pbit != ~^shift register).
  - FERR <= ~stop sample.
  - RINT=1 for exactly one clk.
  - OERR <= 1 if dat_vld=1 and rd=0 in that cycle.
  - dat_vld <= 1.
- ChkEn is sampled at the START->DATA transition and held for the frame.
- rd=1 clears dat_vld and OERR the next clk. rd coincident with completion: new byte lands, dat_vld stays 1, OERR is not set.
- PERR/FERR describe the byte in dat and are overwritten each frame.
- en=0 in any non-IDLE state -> IDLE next clk: frame discarded, no RINT, outputs retained.
- Break (line low through the stop bit): FERR=1 with dat=0x00. No new frame starts until the line has returned high, then fallen again.

Decomposition:
- Package uart_pkg: state encoding (IDLE, START, DATA, PARITY, STOP), OVS default, odd-parity function (~^byte). The transmitter already shares this frame format.
- Sub-module uart_rx_sync: 2-FF synchronizer plus falling-edge detect. Ports clk, rst, din; outputs sync, fall.

Test Plan:
- OVS=16, tick every clk, ChkEn=0, serialize 0xA5 -> one RINT, dat=0xA5, dat_vld=1, PERR=FERR=OERR=0, RINT ~10*16-7 ticks after the start edge.
- ChkEn=1, send 0x3C with parity bit 1 -> PERR=0. Repeat with parity 0 -> dat=0x3C, PERR=1.
- ChkEn=0, send 0x81 with stop bit 0 -> FERR=1, dat=0x81, RINT pulses. Hold the line low 40 bit periods -> no second RINT until high then low.
- Line low for 4 ticks only -> returns to IDLE, busy falls, no RINT, all flags unchanged.
- Frames 0x11 then 0x22 with no rd -> dat=0x22, OERR=1. rd pulse -> dat_vld=0, OERR=0. rd on the completion clk of frame 0x33 -> dat_vld=1, OERR=0.
- Loopback from the transmitter clocked at tick/16, bytes 0x00, 0xFF, 0x55 with ChkEn=1 -> all received intact, no errors. en=0 asserted mid-byte, then rst mid-byte -> no RINT, reset values restored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART frame definitions: receiver state encoding, default oversampling ratio and the
// odd-parity rule also used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned OvsDefault = 16;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RxD line with falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic s1_q, s2_q;

  // Flops idle high so that a line low at reset release is seen as a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  assign sync = s2_q;
  assign fall = s2_q & ~s1_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: majority-voted bit samples, optional odd parity, error flags and
// a valid/read handshake towards the bus.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVS = OvsDefault,
  parameter int unsigned CW  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ChkEn,
  input  logic       tick,
  input  logic       RxD,
  input  logic       rd,
  output logic [7:0] dat,
  output logic       dat_vld,
  output logic       RINT,
  output logic       PERR,
  output logic       FERR,
  output logic       OERR,
  output logic       busy
);

  localparam logic [CW-1:0] TcMid0 = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] TcMid1 = CW'(OVS / 2);
  localparam logic [CW-1:0] TcMid2 = CW'(OVS / 2 + 1);
  localparam logic [CW-1:0] TcEnd  = CW'(OVS - 1);

  logic sync, fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (RxD),
    .sync (sync),
    .fall (fall)
  );

  uart_state_e   state_q, state_d;
  logic [CW-1:0] tc_q, tc_d;
  logic [2:0]    bc_q, bc_d;
  logic [7:0]    sr_q, sr_d, dat_q, dat_d;
  logic [1:0]    smp_q, smp_d;
  logic          pbit_q, pbit_d, chk_q, chk_d;
  logic          vld_q, vld_d, rint_q, rint_d;
  logic          perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;
  logic          maj, at_mid0, at_mid1, at_mid2, bit_end, done, stop_bit;

  assign at_mid0 = tick && (tc_q == TcMid0);
  assign at_mid1 = tick && (tc_q == TcMid1);
  assign at_mid2 = tick && (tc_q == TcMid2);
  assign bit_end = tick && (tc_q == TcEnd);
  // Vote of the two stored samples and the live one at the third sample point.
  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync) | (smp_q[1] & sync);

  always_comb begin
    state_d  = state_q;
    tc_d     = tc_q;
    bc_d     = bc_q;
    sr_d     = sr_q;
    smp_d    = smp_q;
    pbit_d   = pbit_q;
    chk_d    = chk_q;
    done     = 1'b0;
    stop_bit = 1'b1;

    if (tick) tc_d = tc_q + CW'(1);
    if (at_mid0) smp_d[0] = sync;
    if (at_mid1) smp_d[1] = sync;

    case (state_q)
      StIdle: begin
        if (fall && en) state_d = StStart;
      end
      StStart: begin
        if (at_mid2 && maj) begin
          state_d = StIdle;
        end else if (bit_end) begin
          state_d = StData;
          bc_d    = 3'd0;
          chk_d   = ChkEn;
        end
      end
      StData: begin
        if (at_mid2) sr_d = {maj, sr_q[7:1]};
        if (bit_end) begin
          if (bc_q == 3'd7) state_d = chk_q ? StParity : StStop;
          else              bc_d    = bc_q + 3'd1;
        end
      end
      StParity: begin
        if (at_mid2) pbit_d = maj;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (at_mid2) begin
          done     = 1'b1;
          stop_bit = maj;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && !en) begin
      state_d = StIdle;
      done    = 1'b0;
    end

    if (state_d != state_q || bit_end) tc_d = '0;
  end

  always_comb begin
    dat_d  = dat_q;
    vld_d  = vld_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    oerr_d = oerr_q;
    rint_d = 1'b0;
    if (done) begin
      dat_d  = sr_q;
      perr_d = chk_q & (pbit_q != odd_parity(sr_q));
      ferr_d = ~stop_bit;
      // A read landing on the completion clock consumes the old byte, so no overrun.
      oerr_d = (vld_q | oerr_q) & ~rd;
      vld_d  = 1'b1;
      rint_d = 1'b1;
    end else if (rd) begin
      vld_d  = 1'b0;
      oerr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tc_q    <= '0;
      bc_q    <= '0;
      sr_q    <= '0;
      smp_q   <= '0;
      pbit_q  <= 1'b0;
      chk_q   <= 1'b0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      rint_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      bc_q    <= bc_d;
      sr_q    <= sr_d;
      smp_q   <= smp_d;
      pbit_q  <= pbit_d;
      chk_q   <= chk_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      rint_q  <= rint_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign dat     = dat_q;
  assign dat_vld = vld_q;
  assign RINT    = rint_q;
  assign PERR    = perr_q;
  assign FERR    = ferr_q;
  assign OERR    = oerr_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serializes frames onto RxD and checks the received byte,
// flags and handshake against expectations derived from the frame contents.
module tb_uart_rx;

  logic       clk = 1'b0, rst = 1'b1, en = 1'b1, ChkEn = 1'b0, tick = 1'b0, RxD = 1'b1, rd = 1'b0;
  logic [7:0] dat;
  logic       dat_vld, RINT, PERR, FERR, OERR, busy;

  int cmp_cnt = 0, err_cnt = 0;
  int cyc = 0, tdc = 0, tick_div = 1;
  int rint_cnt = 0, rint_cyc = 0, rint_wide = 0;
  logic rint_prev = 1'b0;
  int start_cyc = 0, lat = 156;

  uart_rx #(.OVS(16), .CW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ChkEn   (ChkEn),
    .tick    (tick),
    .RxD     (RxD),
    .rd      (rd),
    .dat     (dat),
    .dat_vld (dat_vld),
    .RINT    (RINT),
    .PERR    (PERR),
    .FERR    (FERR),
    .OERR    (OERR),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tdc >= tick_div - 1) begin
      tdc  <= 0;
      tick <= 1'b1;
    end else begin
      tdc  <= tdc + 1;
      tick <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (RINT) begin
      rint_cnt <= rint_cnt + 1;
      rint_cyc <= cyc;
    end
    if (RINT && rint_prev) rint_wide <= rint_wide + 1;
    rint_prev <= RINT;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_val,
                            input logic stop_val);
    int bp;
    bp = 16 * tick_div;
    @(posedge clk);
    #1;
    RxD = 1'b0;
    start_cyc = cyc;
    hold(bp);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      hold(bp);
    end
    if (par_on) begin
      RxD = par_val;
      hold(bp);
    end
    RxD = stop_val;
    hold(bp);
    RxD = 1'b1;
    hold(bp);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    hold(1);
    rd = 1'b0;
    hold(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hold(4);
    cmp_cnt++;
    if ({dat, dat_vld, RINT, PERR, FERR, OERR, busy} !== 14'h0) begin
      err_cnt++;
      $display("FAIL reset_values: got %h want 0", {dat, dat_vld, RINT, PERR, FERR, OERR, busy});
    end
    rst = 1'b0;
    hold(4);
  endtask

  task automatic test_basic();
    int c;
    ChkEn = 1'b0;
    c = rint_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    cmp_cnt++;
    if (rint_cnt - c !== 1) begin
      err_cnt++; $display("FAIL basic_rint: got %0d pulses want 1", rint_cnt - c);
    end
    cmp_cnt++;
    if (dat !== 8'hA5) begin err_cnt++; $display("FAIL basic_dat: got %h want a5", dat); end
    cmp_cnt++;
    if (dat_vld !== 1'b1) begin err_cnt++; $display("FAIL basic_vld: got %b want 1", dat_vld); end
    cmp_cnt++;
    if ({PERR, FERR, OERR} !== 3'b000) begin
      err_cnt++; $display("FAIL basic_flags: got %b want 000", {PERR, FERR, OERR});
    end
    cmp_cnt++;
    if (rint_cyc - start_cyc < 148 || rint_cyc - start_cyc > 164) begin
      err_cnt++; $display("FAIL basic_latency: got %0d clks want 148..164", rint_cyc - start_cyc);
    end else begin
      lat = rint_cyc - start_cyc;
    end
    pulse_rd();
  endtask

  task automatic test_parity();
    ChkEn = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    cmp_cnt++;
    if ({dat, PERR} !== {8'h3C, 1'b0}) begin
      err_cnt++; $display("FAIL parity_good: got dat=%h perr=%b want 3c/0", dat, PERR);
    end
    pulse_rd();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    cmp_cnt++;
    if ({dat, PERR} !== {8'h3C, 1'b1}) begin
      err_cnt++; $display("FAIL parity_bad: got dat=%h perr=%b want 3c/1", dat, PERR);
    end
    pulse_rd();
    ChkEn = 1'b0;
  endtask

  task automatic test_framing_break();
    int c;
    c = rint_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    cmp_cnt++;
    if ({rint_cnt - c == 1, dat, FERR} !== {1'b1, 8'h81, 1'b1}) begin
      err_cnt++;
      $display("FAIL framing: got rint=%0d dat=%h ferr=%b want 1/81/1", rint_cnt - c, dat, FERR);
    end
    pulse_rd();
    c = rint_cnt;
    @(posedge clk);
    #1;
    RxD = 1'b0;
    hold(640);
    cmp_cnt++;
    if ({rint_cnt - c == 1, dat, FERR} !== {1'b1, 8'h00, 1'b1}) begin
      err_cnt++;
      $display("FAIL break: got rint=%0d dat=%h ferr=%b want 1/00/1", rint_cnt - c, dat, FERR);
    end
    RxD = 1'b1;
    hold(32);
    cmp_cnt++;
    if (rint_cnt - c !== 1) begin
      err_cnt++; $display("FAIL break_retrigger: got %0d pulses want 1", rint_cnt - c);
    end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    cmp_cnt++;
    if ({rint_cnt - c == 2, dat, FERR} !== {1'b1, 8'h5A, 1'b0}) begin
      err_cnt++;
      $display("FAIL after_break: got rint=%0d dat=%h ferr=%b want 2/5a/0", rint_cnt - c, dat,
               FERR);
    end
    pulse_rd();
  endtask

  task automatic test_false_start();
    int c;
    logic [11:0] snap;
    snap = {dat, dat_vld, PERR, FERR, OERR};
    c = rint_cnt;
    @(posedge clk);
    #1;
    RxD = 1'b0;
    hold(4);
    RxD = 1'b1;
    hold(1);
    cmp_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL false_start_busy: got %b want 1", busy); end
    hold(40);
    cmp_cnt++;
    if ({busy, rint_cnt - c == 0, dat, dat_vld, PERR, FERR, OERR} !== {1'b0, 1'b1, snap}) begin
      err_cnt++;
      $display("FAIL false_start_idle: got busy=%b rint=%0d out=%h want 0/0/%h", busy,
               rint_cnt - c, {dat, dat_vld, PERR, FERR, OERR}, snap);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    cmp_cnt++;
    if ({dat, dat_vld, OERR} !== {8'h22, 1'b1, 1'b1}) begin
      err_cnt++; $display("FAIL overrun: got %h/%b/%b want 22/1/1", dat, dat_vld, OERR);
    end
    pulse_rd();
    cmp_cnt++;
    if ({dat_vld, OERR} !== 2'b00) begin
      err_cnt++; $display("FAIL rd_clear: got vld=%b oerr=%b want 0/0", dat_vld, OERR);
    end
    send_frame(8'h44, 1'b0, 1'b0, 1'b1);
    c = rint_cnt;
    fork
      send_frame(8'h33, 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
      end
    join
    cmp_cnt++;
    if ({rint_cnt - c == 1, dat, dat_vld, OERR} !== {1'b1, 8'h33, 1'b1, 1'b0}) begin
      err_cnt++;
      $display("FAIL rd_coincident: got rint=%0d %h/%b/%b want 1/33/1/0", rint_cnt - c, dat,
               dat_vld, OERR);
    end
    pulse_rd();
  endtask

  task automatic test_loopback_random();
    logic [7:0] d;
    logic chk, bad, stopv, parv, m_vld, m_oerr;
    int c;
    m_vld  = 1'b0;
    m_oerr = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i < 3) begin
        d = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h55;
        chk = 1'b1; bad = 1'b0; stopv = 1'b1; tick_div = 1;
      end else begin
        d = 8'($urandom);
        chk = 1'($urandom_range(0, 1));
        bad = ($urandom_range(0, 3) == 0);
        stopv = ($urandom_range(0, 3) != 0);
        tick_div = $urandom_range(1, 2);
      end
      // Odd parity: data ones plus parity bit is odd.
      parv = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
      if (bad) parv = ~parv;
      ChkEn = chk;
      c = rint_cnt;
      send_frame(d, chk, parv, stopv);
      m_oerr = m_vld | m_oerr;
      m_vld  = 1'b1;
      cmp_cnt++;
      if ({rint_cnt - c == 1, dat, dat_vld, PERR, FERR, OERR} !==
          {1'b1, d, m_vld, chk & bad, ~stopv, m_oerr}) begin
        err_cnt++;
        $display("FAIL loopback[%0d]: got rint=%0d dat=%h vld=%b p=%b f=%b o=%b want %h/%b/%b/%b/%b",
                 i, rint_cnt - c, dat, dat_vld, PERR, FERR, OERR, d, m_vld, chk & bad, ~stopv,
                 m_oerr);
      end
      if (i < 3 || $urandom_range(0, 1) == 1) begin
        pulse_rd();
        m_vld  = 1'b0;
        m_oerr = 1'b0;
      end
    end
    tick_div = 1;
    ChkEn = 1'b0;
    hold(4);
  endtask

  task automatic test_abort();
    int c;
    logic [11:0] snap;
    send_frame(8'h6B, 1'b0, 1'b0, 1'b1);
    snap = {dat, dat_vld, PERR, FERR, OERR};
    c = rint_cnt;
    fork
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        hold(16 * 5);
        en = 1'b0;
        hold(1);
        cmp_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL en_abort_busy: got %b want 0", busy); end
        en = 1'b1;
      end
    join
    cmp_cnt++;
    if ({rint_cnt - c == 0, dat, dat_vld, PERR, FERR, OERR} !== {1'b1, snap}) begin
      err_cnt++;
      $display("FAIL en_abort: got rint=%0d out=%h want 0/%h", rint_cnt - c,
               {dat, dat_vld, PERR, FERR, OERR}, snap);
    end
    c = rint_cnt;
    fork
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      begin
        @(posedge clk);
        hold(16 * 5);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
      end
    join
    cmp_cnt++;
    if ({rint_cnt - c == 0, dat, dat_vld, RINT, PERR, FERR, OERR, busy} !== {1'b1, 14'h0}) begin
      err_cnt++;
      $display("FAIL rst_abort: got rint=%0d out=%h want 0/0", rint_cnt - c,
               {dat, dat_vld, RINT, PERR, FERR, OERR, busy});
    end
  endtask

  task automatic test_rint_width();
    cmp_cnt++;
    if (rint_wide !== 0) begin
      err_cnt++; $display("FAIL rint_width: got %0d wide pulses want 0", rint_wide);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing_break();
    test_false_start();
    test_back_to_back();
    test_loopback_random();
    test_abort();
    test_rint_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
